// File: rtl/adder_result_fifo_if.sv
// Result-path bundle for the adder capture FIFO.
//
// Handshake rules:
//   Upstream: the sequencer raises en_in (which also drives the adder's enable)
//   only in a cycle where in_ready is high. The adder's registered
//   {cout_in, sum_in} carries that result one cycle later. An upstream that
//   ignores in_ready may lose results; such losses are counted, never silent.
//   Downstream: an entry moves at a rising edge where out_valid and out_ready
//   are both high. out_valid never depends on out_ready. The head entry
//   (out_data/out_cout) holds steady until it is taken.
interface adder_result_fifo_if #(
   parameter int WIDTH = 32
);
   logic             en_in;
   logic [WIDTH-1:0] sum_in;
   logic             cout_in;
   logic             in_ready;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_cout;

   // FIFO view
   modport slave (
      input  en_in, sum_in, cout_in, out_ready,
      output in_ready, out_valid, out_data, out_cout
   );

   // Environment view: sequencer/adder plus result consumer
   modport master (
      output en_in, sum_in, cout_in, out_ready,
      input  in_ready, out_valid, out_data, out_cout
   );
endinterface

// File: rtl/adder_result_fifo.sv
// Capture stage behind the registered 32-bit adder. It follows the adder's
// enable with a one-cycle pending flag and stores every fresh {cout, sum} in a
// DEPTH-entry FIFO that drains over a valid/ready port. A result that arrives
// while the FIFO is full with no pop is discarded. The discard sets a sticky
// flag and bumps a saturating counter.
// DEPTH must be a power of two and at least 2.
module adder_result_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   adder_result_fifo_if.slave      bus,
   input  logic                    clr_ovf,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    ovf,
   output logic [7:0]              drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
   localparam logic [LW-1:0] LVL_ONE  = LW'(1);
   localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);

   // Storage: carry bit on top of the sum.
   logic [WIDTH:0] mem [DEPTH];

   // The pointers carry a wrap bit above the index bits. Full and empty come
   // from level alone; the wrap bit keeps the pointer distance unambiguous, so
   // that distance can be cross-checked against level.
   logic [AW:0]    wr_ptr;
   logic [AW:0]    rd_ptr;
   logic [LW-1:0]  level_q;
   logic           pend;
   logic           ovf_q;
   logic [7:0]     drop_q;

   logic           push;
   logic           pop;
   logic           empty;
   logic           full;
   logic           push_ok;
   logic           drop;
   logic [LW:0]    occ;
   logic [WIDTH:0] head;
   logic [AW:0]    ptr_gap;

   // Per-cycle transfer decisions. A full FIFO still accepts a result when the
   // head leaves in the same cycle.
   always_comb begin
      push    = pend;
      empty   = (level_q == '0);
      full    = (level_q == FULL_LVL);
      pop     = !empty && bus.out_ready;
      push_ok = push && (!full || pop);
      drop    = push && full && !pop;
   end

   // The in-flight result (pend) is counted as occupied. An upstream that
   // honours in_ready therefore can never overrun the FIFO.
   assign occ          = {1'b0, level_q} + {{LW{1'b0}}, pend};
   assign bus.in_ready = (occ < {1'b0, FULL_LVL});

   // Head entry is registered storage; a write becomes visible one cycle later.
   assign head          = mem[rd_ptr[AW-1:0]];
   assign bus.out_valid = !empty;
   assign bus.out_data  = empty ? '0 : head[WIDTH-1:0];
   assign bus.out_cout  = !empty && head[WIDTH];

   assign level    = level_q;
   assign ovf      = ovf_q;
   assign drop_cnt = drop_q;

   assign ptr_gap = wr_ptr - rd_ptr;

   // Write the accepted adder result into the slot at the write pointer.
   always_ff @(posedge clk) begin
      if (!rst && push_ok) begin
         mem[wr_ptr[AW-1:0]] <= {bus.cout_in, bus.sum_in};
      end
   end

   // Track the adder enable, advance the pointers and keep level in step.
   // Reset drops the pending result and all stored entries without counting
   // them as losses, and ignores an enable seen in the reset cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend    <= 1'b0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else begin
         pend <= bus.en_in;
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         if (push_ok && !pop) begin
            level_q <= level_q + LVL_ONE;
         end else if (pop && !push_ok) begin
            level_q <= level_q - LVL_ONE;
         end
      end
   end

   // Sticky loss flag and saturating loss counter. A loss in the same cycle
   // as a clear wins and restarts the count at one.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q  <= 1'b0;
         drop_q <= '0;
      end else if (drop) begin
         ovf_q <= 1'b1;
         if (clr_ovf) begin
            drop_q <= 8'd1;
         end else if (drop_q != 8'hFF) begin
            drop_q <= drop_q + 8'd1;
         end
      end else if (clr_ovf) begin
         ovf_q  <= 1'b0;
         drop_q <= '0;
      end
   end

   // Pointer distance and level are kept separately and must always agree.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (ptr_gap == level_q);
      end
   end

endmodule
